fetch_pc_unit: RTL

- Program-counter and instruction-fetch stage feeding the opcode/funct3 decoder and the rest of the core.
- Holds the PC and issues a request/acknowledge fetch to instruction memory.
- Presents one fetched instruction per execute slot.
- Computes next PC from the decoder's Branch/Jump/jalr outputs, the extended immediate and the ALU result. Counts retired instructions.

---
 rtl/fetch_pc_unit.sv | 135 +++++++++++++
 1 files changed

// File: rtl/fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit
//   Program counter and instruction-fetch stage. Fetches one instruction at a
//   time over a request/acknowledge interface, holds it in Instr for its execute
//   slot, then computes the next PC from the decoder's control outputs and
//   counts retired instructions.
//
// Ports:
//   clk, reset            core clock; asynchronous active-high reset
//   Branch, Jump, jalr    decoder control, sampled only when retiring
//   ImmExt, ALUResult     branch/jal offset and jalr target source
//   stall                 hold the executing instruction (no retire)
//   imem_req, imem_addr   fetch request and address (= PC)
//   imem_ack, imem_rdata  memory accept and same-cycle instruction word
//   Instr, instr_valid    instruction register and its execute-slot strobe
//   PC, PCPlus4           address of Instr and PC+4 for link writeback
//   misaligned            sticky flag: a taken target had nonzero bits [1:0]
//   retire_count          retired instruction counter (wraps)
// -----------------------------------------------------------------------------
module fetch_pc_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            Branch,
    input  logic            Jump,
    input  logic            jalr,
    input  logic [XLEN-1:0] ImmExt,
    input  logic [XLEN-1:0] ALUResult,
    input  logic            stall,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] Instr,
    output logic            instr_valid,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,
    output logic            misaligned,
    output logic [31:0]     retire_count
);

    localparam logic [XLEN-1:0] NopInstr = XLEN'(32'h0000_0013);

    typedef enum logic [1:0] {StIdle, StFetch, StExec} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic            mis_q, mis_d;
    logic [31:0]     retire_q, retire_d;

    logic            taken;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc_plus4;

    assign pc_plus4 = pc_q + XLEN'(4);

    // jalr has priority over Jump/Branch; its target always has bit 0 cleared.
    always_comb begin
        taken  = 1'b0;
        target = pc_q + ImmExt;
        if (jalr) begin
            taken  = 1'b1;
            target = ALUResult & ~XLEN'(1);
        end else if (Jump || Branch) begin
            taken = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        mis_d    = mis_q;
        retire_d = retire_q;
        unique case (state_q)
            StIdle: begin
                state_d = StFetch;
            end
            StFetch: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = StExec;
                end
            end
            StExec: begin
                if (!stall) begin
                    retire_d = retire_q + 32'd1;
                    state_d  = StFetch;
                    if (taken) begin
                        // Misaligned targets are flagged and then forced onto a word boundary.
                        pc_d = target & ~XLEN'(3);
                        if (target[1:0] != 2'b00) begin
                            mis_d = 1'b1;
                        end
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            pc_q     <= RESET_PC;
            instr_q  <= NopInstr;
            mis_q    <= 1'b0;
            retire_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            mis_q    <= mis_d;
            retire_q <= retire_d;
        end
    end

    // Request and valid decode straight from state so reset drops them immediately.
    assign imem_req     = (state_q == StFetch);
    assign imem_addr    = pc_q;
    assign instr_valid  = (state_q == StExec);
    assign Instr        = instr_q;
    assign PC           = pc_q;
    assign PCPlus4      = pc_plus4;
    assign misaligned   = mis_q;
    assign retire_count = retire_q;

endmodule
